line_miss_ctrl: RTL
===================

Name: line_miss_ctrl

Overview:
Requester-facing lookup and miss handler directly upstream of fetch_ctrl, driving one of its three fetch ports. It holds the tag/valid/dirty directory for the list_depth line slots and serves word reads and writes from the shared line memory on a hit. On a miss it picks a victim round-robin, issues a write-back (cmd 00) if the victim is dirty, issues a refill (cmd 01), then replays the lookup.

Parameters:
addr_width, 32, word address width
list_depth, 4, number of line slots; power of 2, >=2
data_width, 32, word width
list_width, 32, words per line; power of 2. OW = $clog2(list_width), SW = $clog2(list_depth)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  requester access valid
req_ready  out  1  block can accept an access
req_addr  in  addr_width  word address
req_wr  in  1  1 = write, 0 = read
req_wdata  in  data_width  write data
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  data_width  read data; 0 for writes
fetch_cmd  out  2  00 = write-back, 01 = refill
fetch_req  out  1  fetch request
fetch_tag  out  SW  slot index
fetch_addr  out  addr_width  line base word address
fetch_gnt  in  1  fetch grant
fetch_done  in  1  fetch completion pulse
lm_addr  out  SW+OW  line memory address {slot, offset}
lm_ren  out  1  line memory read; data returned 1 cycle later
lm_wen  out  1  line memory write
lm_wdata  out  data_width  line memory write data
lm_rdata  in  data_width  line memory read data

Behaviour:
- Address split: offset = addr[OW-1:0]; line tag = addr[addr_width-1:OW]. Each slot stores the full line tag plus valid and dirty bits.
- Reset values: all valid and dirty bits 0, victim_ptr = 0, state IDLE. Outputs: req_ready = 1, and rsp_valid, rsp_data, fetch_req, fetch_cmd, fetch_tag, fetch_addr, lm_* all 0.
- Reset mid-operation: all outputs drop immediately. The directory is cleared and any outstanding fetch is abandoned. The system resets fetch_ctrl on the same reset.
- States: IDLE, LOOKUP, HIT_RSP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT.
- IDLE: req_ready = 1. On req_valid, latch addr/wr/wdata and go to LOOKUP. req_ready = 0 in every other state.
- LOOKUP: compare the latched tag against all valid slots in parallel. At most one slot can match.
  - Read hit: lm_ren = 1, lm_addr = {slot, offset}; go to HIT_RSP.
  - Write hit: lm_wen = 1, lm_wdata = wdata, set dirty[slot]; go to HIT_RSP.
  - Miss, victim valid and dirty: go to WB_REQ.
  - Miss, victim clean or invalid: go to RF_REQ.
- HIT_RSP: rsp_valid = 1 for exactly one cycle. rsp_data = lm_rdata for a read, 0 for a write. Return to IDLE.
- Hit latency: req accept at cycle t, LOOKUP at t+1, rsp_valid at t+2. The next request can be accepted at t+3.
- WB_REQ: fetch_req = 1, fetch_cmd = 00, fetch_tag = victim_ptr, fetch_addr = {stored_tag[victim], OW'b0}. Hold all fetch outputs stable until fetch_gnt, then go to WB_WAIT.
- WB_WAIT: fetch_req = 0. On fetch_done, clear valid and dirty of the victim and go to RF_REQ.
- RF_REQ: fetch_req = 1, fetch_cmd = 01, fetch_tag = victim_ptr, fetch_addr = {latched tag, OW'b0}. Hold until fetch_gnt, then go to RF_WAIT.
- RF_WAIT: on fetch_done, set valid = 1, stored tag = latched tag, dirty = 0, victim_ptr = victim_ptr + 1 (wraps list_depth-1 -> 0). Return to LOOKUP; the replay then hits.
- fetch_done is sampled only in WB_WAIT and RF_WAIT and is ignored in all other states. fetch_gnt is sampled only while fetch_req = 1.
- During WB_* and RF_*, lm_ren = lm_wen = 0, because fetch_ctrl owns the line memory.
- lm_ren and lm_wen are mutually exclusive and are asserted only in LOOKUP on a hit.
- No response backpressure: the requester must accept rsp_valid.
- Miss latency = 1 (LOOKUP) + grant wait + done wait (+ write-back) + 2 (LOOKUP, HIT_RSP).

Test Plan:
- Cold read of addr 0x40 (list_width 32) -> fetch_cmd = 01, fetch_tag = 0, fetch_addr = 0x40. After fetch_done: lm_ren with lm_addr = {0, 0}, then rsp_valid with lm_rdata. valid[0] = 1, victim_ptr = 1.
- Read hit on 0x45 after the first test -> no fetch_req; lm_addr = {0, 5}; rsp_valid exactly 2 cycles after accept.
- Write hit on 0x41 with data 0xDEADBEEF -> lm_wen, lm_addr = {0, 1}, dirty[0] = 1; rsp_valid with rsp_data = 0.
- Fill 4 lines (0x00, 0x20, 0x40, 0x60), write 0x00, then read 0x80 -> write-back cmd 00, tag 0, addr 0x00, then refill cmd 01, tag 0, addr 0x80. victim_ptr wraps 3 -> 0 -> 1.
- Hold fetch_gnt low for 10 cycles in RF_REQ -> fetch_req, fetch_addr and fetch_tag stay stable and req_ready = 0. A spurious fetch_done in RF_REQ is ignored.
- Assert rst_n low during RF_WAIT -> fetch_req = 0 and req_ready = 1 immediately; after release, a read of the same address misses again.

Source files
------------

// File: rtl/line_miss_ctrl.sv
// Line directory and miss handler in front of fetch_ctrl: serves word hits from the
// shared line memory and runs write-back/refill through one fetch port on a miss.
module line_miss_ctrl #(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32,
  localparam int OW = $clog2(list_width),
  localparam int SW = $clog2(list_depth)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [addr_width-1:0] req_addr,
  input  logic                  req_wr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [data_width-1:0] rsp_data,
  output logic [1:0]            fetch_cmd,
  output logic                  fetch_req,
  output logic [SW-1:0]         fetch_tag,
  output logic [addr_width-1:0] fetch_addr,
  input  logic                  fetch_gnt,
  input  logic                  fetch_done,
  output logic [SW+OW-1:0]      lm_addr,
  output logic                  lm_ren,
  output logic                  lm_wen,
  output logic [data_width-1:0] lm_wdata,
  input  logic [data_width-1:0] lm_rdata
);

  localparam int TW = addr_width - OW;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_HIT_RSP = 3'd2;
  localparam logic [2:0] S_WB_REQ  = 3'd3;
  localparam logic [2:0] S_WB_WAIT = 3'd4;
  localparam logic [2:0] S_RF_REQ  = 3'd5;
  localparam logic [2:0] S_RF_WAIT = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [data_width-1:0] wdata_q, wdata_d;
  logic [list_depth-1:0] valid_q, valid_d;
  logic [list_depth-1:0] dirty_q, dirty_d;
  logic [TW-1:0]         tag_q [list_depth];
  logic [TW-1:0]         tag_d [list_depth];
  logic [SW-1:0]         victim_q, victim_d;

  logic                  hit_s;
  logic [SW-1:0]         hit_slot_s;
  logic [TW-1:0]         req_tag_s;
  logic [OW-1:0]         req_off_s;

  assign req_tag_s = addr_q[addr_width-1:OW];
  assign req_off_s = addr_q[OW-1:0];

  // Parallel tag compare; tags are unique among valid slots so at most one matches
  always_comb begin
    hit_s      = 1'b0;
    hit_slot_s = '0;
    for (int i = 0; i < list_depth; i++) begin
      hit_s      = hit_s | (valid_q[i] & (tag_q[i] == req_tag_s));
      hit_slot_s = (valid_q[i] && (tag_q[i] == req_tag_s)) ? SW'(i) : hit_slot_s;
    end
  end

  // Next state, request latch and directory updates
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    tag_d    = tag_q;
    victim_d = victim_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_LOOKUP;
          addr_d  = req_addr;
          wr_d    = req_wr;
          wdata_d = req_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (hit_s) begin
          state_d             = S_HIT_RSP;
          dirty_d[hit_slot_s] = dirty_q[hit_slot_s] | wr_q;
        end else if (valid_q[victim_q] && dirty_q[victim_q]) begin
          state_d = S_WB_REQ;
        end else begin
          state_d = S_RF_REQ;
        end
      end
      S_HIT_RSP: state_d = S_IDLE;
      S_WB_REQ:  state_d = fetch_gnt ? S_WB_WAIT : S_WB_REQ;
      S_WB_WAIT: begin
        if (fetch_done) begin
          valid_d[victim_q] = 1'b0;
          dirty_d[victim_q] = 1'b0;
          state_d           = S_RF_REQ;
        end else begin
          state_d = S_WB_WAIT;
        end
      end
      S_RF_REQ:  state_d = fetch_gnt ? S_RF_WAIT : S_RF_REQ;
      S_RF_WAIT: begin
        // Install the new line and replay the lookup, which now hits
        if (fetch_done) begin
          valid_d[victim_q] = 1'b1;
          dirty_d[victim_q] = 1'b0;
          tag_d[victim_q]   = req_tag_s;
          victim_d          = victim_q + SW'(1);
          state_d           = S_LOOKUP;
        end else begin
          state_d = S_RF_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    fetch_req  = 1'b0;
    fetch_cmd  = 2'b00;
    fetch_tag  = '0;
    fetch_addr = '0;
    lm_addr    = '0;
    lm_ren     = 1'b0;
    lm_wen     = 1'b0;
    lm_wdata   = '0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_LOOKUP: begin
        if (hit_s) begin
          lm_addr  = {hit_slot_s, req_off_s};
          lm_ren   = ~wr_q;
          lm_wen   = wr_q;
          lm_wdata = wr_q ? wdata_q : '0;
        end else begin
          lm_addr = '0;
        end
      end
      S_HIT_RSP: begin
        rsp_valid = 1'b1;
        rsp_data  = wr_q ? '0 : lm_rdata;
      end
      S_WB_REQ: begin
        fetch_req  = 1'b1;
        fetch_cmd  = 2'b00;
        fetch_tag  = victim_q;
        fetch_addr = {tag_q[victim_q], {OW{1'b0}}};
      end
      S_RF_REQ: begin
        fetch_req  = 1'b1;
        fetch_cmd  = 2'b01;
        fetch_tag  = victim_q;
        fetch_addr = {req_tag_s, {OW{1'b0}}};
      end
      default: req_ready = 1'b0;
    endcase
  end

  // State and directory registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      victim_q <= '0;
      for (int i = 0; i < list_depth; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      victim_q <= victim_d;
      for (int i = 0; i < list_depth; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule
